mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory access unit directly upstream of the processor memory interface. Accepts instruction-fetch and load/store requests from the core, arbitrates between them, and drives the interface's single `mem_rd`/`mem_wr`/`address`/`data_in` port. It waits on `mfc` and returns aligned, sign/zero-extended read data. The memory port writes whole 32-bit words only, so sub-word stores are done as read-modify-write. A cycle timeout turns accesses to unmapped space, which never raise `mfc`, into error responses.

## Interface
- `TIMEOUT`, 16: cycles an access phase waits for `mem_mfc` before erroring; legal range 2..255.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  32  fetch byte address.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_rdata`  out  32  fetched word; valid with `if_ack`.
- `if_err`  out  1  error flag; valid with `if_ack`.
- `ls_req`  in  1  load/store request; held with all `ls_*` fields until `ls_ack`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `ls_unsigned`  in  1  zero-extend loads when set.
- `ls_addr`  in  32  byte address.
- `ls_wdata`  in  32  store data; the value is in the low bits.
- `ls_ack`  out  1  one-cycle completion pulse.
- `ls_rdata`  out  32  extended load data; valid with `ls_ack`.
- `ls_err`  out  1  error flag; valid with `ls_ack`.
- `mem_addr`  out  32  word-aligned address to the memory interface.
- `mem_wdata`  out  32  write data to the memory interface.
- `mem_rd`  out  1  read strobe.
- `mem_wr`  out  1  write strobe.
- `mem_rdata`  in  32  read data from the memory interface.
- `mem_mfc`  in  1  memory function complete.

## Operation
- **States:** IDLE, RD, MERGE, WR, RESP.
- **IDLE, arbitration:** when both requests are pending, `ls_req` wins over `if_req`. The grant, address and fields are registered.
- **Alignment check (in IDLE):**
  - Error if `ls_size`=11.
  - Error if half access with `addr[0]`=1.
  - Error if word access or fetch with `addr[1:0]`≠0.
  - On error, go to RESP with the error flag set. No memory strobe is issued.
- **Strobes:** `mem_addr` = {addr[31:2], 2'b00}. Lanes are little-endian and selected by `addr[1:0]`.
- **Load, fetch or word store:**
  - RD for loads and fetches; WR for word stores, with `mem_wdata` = `ls_wdata`.
  - On `mem_mfc`=1, register the data, drop the strobe, go to RESP.
- **Sub-word store:**
  1. RD: on `mem_mfc`, go to MERGE with the old word.
  2. MERGE: replace the selected byte or half with `ls_wdata[7:0]` or `[15:0]`. Strobes stay low.
  3. WR: write the merged word; on `mem_mfc`, go to RESP.
- **Load extraction:** the selected byte or half is sign-extended, or zero-extended when `ls_unsigned`=1. Word loads pass through unchanged.
- **Timeout:**
  - A counter clears on entry to RD or WR and increments each cycle `mem_mfc`=0.
  - When it reaches `TIMEOUT`: drop the strobe, set err, go to RESP, rdata=0.
  - A timeout in the RD phase of a read-modify-write skips the write.
- **RESP:** pulse the granted port's ack with rdata/err. Next state is IDLE.
- **Reset:** all outputs and registers are 0 and the state is IDLE. Reset mid-access abandons it without an ack.

## Timing
- Requests are sampled at the edge ending IDLE; `mem_rd`/`mem_wr` rise at that edge.
- Best-case latency, with `mem_mfc` in the first strobe cycle:
  - Load, fetch or word store: ack 2 cycles after the sampling edge.
  - Sub-word store: ack 4 cycles after the sampling edge.
  - Alignment error: ack 1 cycle after the sampling edge.
- `mem_rd` and `mem_wr` are never high together. At least one cycle with both low separates any two strobes.
- Timeout: ack at `TIMEOUT`+1 cycles after the strobe rises.
- A requester whose `req` stays high after its ack is re-arbitrated in the IDLE cycle following RESP. The back-to-back throughput is one access per 3 cycles minimum.
- Outputs are registered; there is no combinational path from `mem_mfc` to any ack.

## Structure
- Package `mau_pkg`:
  - `size_t` enum: BYTE, HALF, WORD, ILL.
  - `state_t` enum: the five states.
  - `TIMEOUT_DEF` = 16.
- Sub-module `lane_align`, combinational, with two functions:
  - Load extraction/extension: `addr[1:0]`, size, unsigned, word → rdata.
  - Store merge: `addr[1:0]`, size, old word, wdata → new word.
- The top level holds the FSM, arbiter and timeout counter.

## Test plan
- **Fetch:** fetch `0x0000_0010`, memory word `0xDEAD_BEEF`, mfc immediate → `if_ack` 2 cycles after sample, `if_rdata`=`DEADBEEF`, `if_err`=0.
- **Signed byte load:** LB (signed), addr `0x0003_0003`, word `0x8011_2233` → `mem_addr`=`0x0003_0000`, `ls_rdata`=`0xFFFF_FF80`. Same access with `ls_unsigned`=1 → `0x0000_0080`.
- **Half store (RMW):** SH `0xABCD` to `0x0003_0002`, old word `0x1122_3344` → RD, then MERGE, then WR with `mem_wdata`=`0xABCD_3344`, ack at cycle 4, one idle cycle between strobes.
- **Arbitration:** `if_req` and `ls_req` rise together → LSU served first, then fetch, with `ls_ack` and `if_ack` 3 cycles apart.
- **Error cases:**
  - LW at `0x0003_0002` → `ls_err`=1 after 1 cycle, no strobe.
  - Load from `0x0001_8000` with `mem_mfc` held 0 → `ls_err`=1 at `TIMEOUT`+1 cycles, `mem_rd` drops.
- **Reset mid-access:** assert `rst_n`=0 during WR of an RMW → outputs 0 immediately, no ack. After release, a new request completes normally.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit: access sizes, FSM states
// and the alignment rule applied to every request before it reaches memory.
package mau_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeIll  = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StMerge,
    StWr,
    StResp
  } state_t;

  localparam int unsigned TIMEOUT_DEF = 16;

  function automatic logic access_err(size_t size, logic [1:0] addr_lo);
    logic err;
    case (size)
      SizeByte: err = 1'b0;
      SizeHalf: err = addr_lo[0];
      SizeWord: err = (addr_lo != 2'b00);
      default:  err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian byte-lane steering: extracts and extends load data from a word,
// and merges sub-word store data into an old word for read-modify-write.
module lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    rdata_o  = word_i;
    merged_o = word_i;
    sign     = 1'b0;
    case (size_i)
      SizeByte: begin
        sign     = byte_sel[7] & ~unsigned_i;
        rdata_o  = {{24{sign}}, byte_sel};
        merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SizeHalf: begin
        sign    = half_sel[15] & ~unsigned_i;
        rdata_o = {{16{sign}}, half_sel};
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Arbitrates fetch and load/store requests onto a single word-wide memory port,
// with read-modify-write for sub-word stores and a timeout for unmapped space.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_unsigned_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_ack_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_mfc_i
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_t      state_q;
  size_t       size_q;
  logic        is_ls_q, we_q, uns_q, err_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q, data_q;
  logic [7:0]  cnt_q;
  logic        if_ack_q, if_err_q, ls_ack_q, ls_err_q, mem_rd_q, mem_wr_q;
  logic [31:0] if_rdata_q, ls_rdata_q, mem_addr_q, mem_wdata_q;

  logic        sel_ls, req_we, req_err, cnt_done;
  size_t       req_size;
  logic [31:0] req_addr, ext_rdata, merged;

  // Load/store always wins arbitration over fetch.
  assign sel_ls   = ls_req_i;
  assign req_size = sel_ls ? size_t'(ls_size_i) : SizeWord;
  assign req_addr = sel_ls ? ls_addr_i : if_addr_i;
  assign req_we   = sel_ls & ls_we_i;
  assign req_err  = access_err(req_size, req_addr[1:0]);
  assign cnt_done = (cnt_q == CntLast);

  lane_align u_lane_align (
    .addr_lo_i  (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .word_i     (data_q),
    .wdata_i    (wdata_q),
    .rdata_o    (ext_rdata),
    .merged_o   (merged)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      size_q      <= SizeByte;
      is_ls_q     <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      addr_lo_q   <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_ack_q    <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      ls_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ls_req_i || if_req_i) begin
            is_ls_q    <= sel_ls;
            we_q       <= req_we;
            size_q     <= req_size;
            uns_q      <= ls_unsigned_i;
            addr_lo_q  <= req_addr[1:0];
            wdata_q    <= ls_wdata_i;
            mem_addr_q <= {req_addr[31:2], 2'b00};
            cnt_q      <= '0;
            data_q     <= '0;
            err_q      <= req_err;
            if (req_err) begin
              state_q <= StResp;
            end else if (req_we && req_size == SizeWord) begin
              mem_wdata_q <= ls_wdata_i;
              mem_wr_q    <= 1'b1;
              state_q     <= StWr;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= StRd;
            end
          end
        end
        StRd: begin
          if (mem_mfc_i) begin
            mem_rd_q <= 1'b0;
            data_q   <= mem_rdata_i;
            state_q  <= we_q ? StMerge : StResp;
          end else if (cnt_done) begin
            // A read timeout also abandons the write half of a read-modify-write.
            mem_rd_q <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StMerge: begin
          data_q      <= merged;
          mem_wdata_q <= merged;
          mem_wr_q    <= 1'b1;
          cnt_q       <= '0;
          state_q     <= StWr;
        end
        StWr: begin
          if (mem_mfc_i) begin
            mem_wr_q <= 1'b0;
            state_q  <= StResp;
          end else if (cnt_done) begin
            mem_wr_q <= 1'b0;
            err_q    <= 1'b1;
            data_q   <= '0;
            state_q  <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (is_ls_q) begin
            ls_ack_q   <= 1'b1;
            ls_err_q   <= err_q;
            ls_rdata_q <= we_q ? '0 : ext_rdata;
          end else begin
            if_ack_q   <= 1'b1;
            if_err_q   <= err_q;
            if_rdata_q <= data_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_ack_o    = ls_ack_q;
  assign ls_err_o    = ls_err_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a latency-programmable memory model
// plus a transaction-level reference that predicts data, errors and ack timing.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_unsigned, ls_ack, ls_err;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_mfc;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .if_req_i      (if_req),
    .if_addr_i     (if_addr),
    .if_ack_o      (if_ack),
    .if_rdata_o    (if_rdata),
    .if_err_o      (if_err),
    .ls_req_i      (ls_req),
    .ls_we_i       (ls_we),
    .ls_size_i     (ls_size),
    .ls_unsigned_i (ls_unsigned),
    .ls_addr_i     (ls_addr),
    .ls_wdata_i    (ls_wdata),
    .ls_ack_o      (ls_ack),
    .ls_rdata_o    (ls_rdata),
    .ls_err_o      (ls_err),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rd_o      (mem_rd),
    .mem_wr_o      (mem_wr),
    .mem_rdata_i   (mem_rdata),
    .mem_mfc_i     (mem_mfc)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          mem_lat = 0;
  int          strobe_cnt = 0;
  int          cyc = 0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] env_mem [64];
  logic [31:0] ref_mem [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit is_mapped(input logic [31:0] a);
    return a[31:16] != 16'h0001;
  endfunction

  // Memory environment: mfc after mem_lat extra cycles; region 0x0001_xxxx never answers.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_mfc = 1'b0;
      cyc     = 0;
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if ((mem_rd && !prev_rd) || (mem_wr && !prev_wr)) begin
        strobe_cnt++;
        last_addr = mem_addr;
        chk("strobe_gap", {30'd0, prev_rd, prev_wr}, 32'd0);
        chk("strobe_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      end
      if (mem_rd || mem_wr) begin
        if (is_mapped(mem_addr) && cyc == mem_lat) begin
          mem_mfc = 1'b1;
          if (mem_rd) mem_rdata = env_mem[mem_addr[7:2]];
          else        env_mem[mem_addr[7:2]] = mem_wdata;
        end else begin
          mem_mfc = 1'b0;
        end
        cyc++;
      end else begin
        mem_mfc = 1'b0;
        cyc     = 0;
      end
      prev_rd = mem_rd;
      prev_wr = mem_wr;
    end
  end

  // Issues one request from a quiet IDLE cycle and checks it against the model.
  task automatic do_access(input bit ls, input bit we, input logic [1:0] sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd, input int lat,
                           input string tag);
    logic [1:0]  esz;
    logic [31:0] old, val, mask, exp_rdata;
    int          sh, exp_lat, n, strobes0;
    bit          aerr, exp_err, store, got_ack;
    esz   = ls ? sz : 2'd2;
    store = ls && we;
    sh    = 8 * int'(addr[1:0]);
    aerr  = (esz == 2'd3) || (esz == 2'd1 && addr[0]) || (esz == 2'd2 && addr[1:0] != 2'd0);
    exp_rdata = 32'd0;
    if (aerr) begin
      exp_err = 1; exp_lat = 1;
    end else if (!is_mapped(addr)) begin
      exp_err = 1; exp_lat = TO + 1;
    end else begin
      exp_err = 0;
      old     = ref_mem[addr[7:2]];
      mask    = (esz == 2'd0) ? 32'hFF : 32'hFFFF;
      if (!store) begin
        exp_lat = 2 + lat;
        if (esz == 2'd2) begin
          exp_rdata = old;
        end else begin
          val = (old >> sh) & mask;
          if (!uns && esz == 2'd0 && val >= 32'd128)   val = val - 32'd256;
          if (!uns && esz == 2'd1 && val >= 32'd32768) val = val - 32'd65536;
          exp_rdata = val;
        end
      end else if (esz == 2'd2) begin
        exp_lat = 2 + lat;
        ref_mem[addr[7:2]] = wd;
      end else begin
        exp_lat = 4 + 2 * lat;
        ref_mem[addr[7:2]] = (old & ~(mask << sh)) | ((wd & mask) << sh);
      end
    end
    strobes0 = strobe_cnt;
    mem_lat  = lat;
    if (ls) begin
      ls_req = 1; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    n = 0;
    got_ack = 0;
    while (!got_ack && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (ls ? if_ack : ls_ack) chk({tag, "_wrong_ack"}, 32'd1, 32'd0);
      got_ack = ls ? ls_ack : if_ack;
    end
    if (!got_ack) begin
      chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"}, n - 1, exp_lat);
      chk({tag, "_err"}, {31'd0, ls ? ls_err : if_err}, {31'd0, exp_err});
      if (!store) chk({tag, "_rdata"}, ls ? ls_rdata : if_rdata, exp_rdata);
      chk({tag, "_strobes_idle"}, {30'd0, mem_rd, mem_wr}, 32'd0);
      if (aerr) chk({tag, "_no_strobe"}, strobe_cnt, strobes0);
      else      chk({tag, "_addr"}, last_addr, {addr[31:2], 2'b00});
      if (store && is_mapped(addr) && !aerr)
        chk({tag, "_memword"}, env_mem[addr[7:2]], ref_mem[addr[7:2]]);
    end
    ls_req = 0;
    if_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int          t_ls, t_if, n;
    logic        ls, we, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wd;
    rst_n = 0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_size = 0;
    ls_unsigned = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; mem_mfc = 0;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("reset_acks", {28'd0, if_ack, if_err, ls_ack, ls_err}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_rdata", ls_rdata | if_rdata | mem_wdata, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    env_mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    do_access(0, 0, 2'd2, 0, 32'h0000_0010, 0, 0, "fetch");
    env_mem[0] = 32'h8011_2233; ref_mem[0] = 32'h8011_2233;
    do_access(1, 0, 2'd0, 0, 32'h0003_0003, 0, 0, "lb");
    do_access(1, 0, 2'd0, 1, 32'h0003_0003, 0, 0, "lbu");
    env_mem[0] = 32'h1122_3344; ref_mem[0] = 32'h1122_3344;
    do_access(1, 1, 2'd1, 0, 32'h0003_0002, 32'h0000_ABCD, 0, "sh_rmw");
    chk("sh_rmw_word", env_mem[0], 32'hABCD_3344);
    do_access(1, 0, 2'd2, 0, 32'h0003_0002, 0, 0, "lw_misalign");
    do_access(1, 0, 2'd2, 0, 32'h0001_8000, 0, 0, "timeout");
    do_access(1, 1, 2'd0, 0, 32'h0001_8001, 32'h55, 0, "sb_timeout");

    // Simultaneous requests: load/store first, fetch three cycles later.
    mem_lat = 0;
    ls_req = 1; ls_we = 0; ls_size = 2'd2; ls_unsigned = 0; ls_addr = 32'h0003_0008;
    if_req = 1; if_addr = 32'h0003_000C;
    t_ls = 0; t_if = 0; n = 0;
    while (t_if == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (ls_ack) begin
        t_ls = n; ls_req = 0;
        chk("arb_ls_rdata", ls_rdata, ref_mem[2]);
      end
      if (if_ack) begin
        t_if = n; if_req = 0;
        chk("arb_if_rdata", if_rdata, ref_mem[3]);
      end
    end
    chk("arb_ls_lat", t_ls, 3);
    chk("arb_gap", t_if - t_ls, 3);
    ls_req = 0; if_req = 0;
    @(posedge clk); #1;

    // Reset during the write phase of a byte read-modify-write.
    mem_lat = 5;
    ls_req = 1; ls_we = 1; ls_size = 2'd0; ls_unsigned = 0; ls_addr = 32'h0003_0005;
    ls_wdata = 32'h0000_00A5;
    n = 0;
    while (!mem_wr && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reached_wr", {31'd0, mem_wr}, 32'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_mid_outs", mem_addr | mem_wdata | ls_rdata, 32'd0);
    ls_req = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_mid_noack", {30'd0, ls_ack, if_ack}, 32'd0);
    end
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_mid_nowrite", env_mem[1], ref_mem[1]);
    do_access(1, 0, 2'd0, 1, 32'h0003_0005, 0, 1, "post_rst_lbu");

    for (int i = 0; i < 200; i++) begin
      ls  = ($urandom_range(3) != 0);
      we  = $urandom_range(1);
      uns = $urandom_range(1);
      sz  = 2'($urandom_range(3));
      wd  = $urandom;
      if ($urandom_range(9) == 0) addr = 32'h0001_0000 | 32'($urandom_range(255));
      else                        addr = 32'h0003_0000 | 32'($urandom_range(255));
      if (!ls && $urandom_range(3) != 0) addr[1:0] = 2'b00;
      do_access(ls, we, sz, uns, addr, wd, int'($urandom_range(3)), "rand");
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
